// File: rtl/cdb_result_queue.sv
// ---------------------------------------------------------------------------
// cdb_result_queue
//   A holding queue for one functional unit's completed results, sitting in
//   front of one CDB arbiter request port. Results are captured in completion
//   order, and the oldest one is presented to the arbiter until it is granted.
//
// Handshake semantics (both sides, sampled at the rising edge of clk):
//   push : fuValid && fuReady  -> the entry at tail is written, and tail advances
//   pop  : request && grant    -> the head entry is released, and head advances
//   fuReady and request depend only on registered occupancy. There is no
//   combinational path from grant to fuReady, so a full queue refuses a push
//   even when it is popped in the same cycle. A grant while request is low,
//   and a fuValid while fuReady is low, both have no effect.
//
// Ports:
//   clk           clock
//   clear         asynchronous active-low reset; empties the queue and zeroes storage
//   flush         synchronous flush; empties the queue at the next edge and
//                 overrides any push or pop in the same cycle
//   fuValid/fuResult/fuRob/fuAddress/fuControl   result from the functional unit
//   fuReady       queue can accept a push this cycle
//   request       head entry valid (arbiter request)
//   grant         arbiter grant for this queue
//   result/robEntry/fetchAddress/controlPC        head entry fields
//   count         number of occupied entries
// ---------------------------------------------------------------------------
module cdb_result_queue #(
  parameter int WIDTH   = 31,
  parameter int ROB     = 2,
  parameter int CONTROL = 6,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      flush,
  input  logic                      fuValid,
  input  logic [WIDTH:0]            fuResult,
  input  logic [ROB:0]              fuRob,
  input  logic [WIDTH:0]            fuAddress,
  input  logic [CONTROL:0]          fuControl,
  output logic                      fuReady,
  output logic                      request,
  input  logic                      grant,
  output logic [WIDTH:0]            result,
  output logic [ROB:0]              robEntry,
  output logic [WIDTH:0]            fetchAddress,
  output logic [CONTROL:0]          controlPC,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] L_FULL = (PW+1)'(DEPTH);

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
  logic [WIDTH:0]   r_result  [DEPTH];
  logic [ROB:0]     r_rob     [DEPTH];
  logic [WIDTH:0]   r_address [DEPTH];
  logic [CONTROL:0] r_control [DEPTH];

  logic w_ready;
  logic w_request;
  logic w_push;
  logic w_pop;

  assign w_ready   = (r_count != L_FULL);
  assign w_request = (r_count != '0);
  assign w_push    = fuValid && w_ready;
  assign w_pop     = w_request && grant;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_result[i]  <= '0;
        r_rob[i]     <= '0;
        r_address[i] <= '0;
        r_control[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left untouched. With count at zero, its contents are unobservable.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_result[r_tail]  <= fuResult;
        r_rob[r_tail]     <= fuRob;
        r_address[r_tail] <= fuAddress;
        r_control[r_tail] <= fuControl;
        r_tail            <= r_tail + 1'b1;  // DEPTH is a power of two, so wrap is natural
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign fuReady      = w_ready;
  assign request      = w_request;
  assign count        = r_count;
  assign result       = r_result[r_head];
  assign robEntry     = r_rob[r_head];
  assign fetchAddress = r_address[r_head];
  assign controlPC    = r_control[r_head];

endmodule

// File: tb/tb_cdb_result_queue.sv
module tb_cdb_result_queue;

  logic        clk;
  logic        clear;
  logic        flush;
  logic        fuValid;
  logic [31:0] fuResult;
  logic [2:0]  fuRob;
  logic [31:0] fuAddress;
  logic [6:0]  fuControl;
  logic        fuReady;
  logic        request;
  logic        grant;
  logic [31:0] result;
  logic [2:0]  robEntry;
  logic [31:0] fetchAddress;
  logic [6:0]  controlPC;
  logic [2:0]  count;

  int n_cmp;
  int n_fail;

  cdb_result_queue #(.WIDTH(31), .ROB(2), .CONTROL(6), .DEPTH(4)) dut (
    .clk          (clk),
    .clear        (clear),
    .flush        (flush),
    .fuValid      (fuValid),
    .fuResult     (fuResult),
    .fuRob        (fuRob),
    .fuAddress    (fuAddress),
    .fuControl    (fuControl),
    .fuReady      (fuReady),
    .request      (request),
    .grant        (grant),
    .result       (result),
    .robEntry     (robEntry),
    .fetchAddress (fetchAddress),
    .controlPC    (controlPC),
    .count        (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a result for one edge. The address and control fields are derived from the value.
  task automatic push(input logic [31:0] val, input logic [2:0] rob, input logic g);
    fuValid   = 1'b1;
    fuResult  = val;
    fuRob     = rob;
    fuAddress = val + 32'd1000;
    fuControl = val[6:0] + 7'd3;
    grant     = g;
    tick();
    fuValid   = 1'b0;
    grant     = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] val);
    check(tag, result, val);
    grant = 1'b1;
    tick();
    grant = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    clear = 1'b0; flush = 1'b0; fuValid = 1'b0; grant = 1'b0;
    fuResult = '0; fuRob = '0; fuAddress = '0; fuControl = '0;

    // Reset: clear low for 2 cycles
    tick(); tick();
    check("rst_request", request, 0);
    check("rst_ready",   fuReady, 1);
    check("rst_count",   count,   0);
    check("rst_result",  result,  0);
    check("rst_addr",    fetchAddress, 0);
    clear = 1'b1;
    tick();
    check("post_rst_count", count, 0);

    // grant while empty is ignored
    grant = 1'b1; tick(); grant = 1'b0;
    check("idle_grant_count", count, 0);
    check("idle_grant_ready", fuReady, 1);

    // Single pass-through with grant held high
    push(32'd60, 3'd1, 1'b1);
    check("pt_request", request, 1);
    check("pt_result",  result, 60);
    check("pt_rob",     robEntry, 1);
    check("pt_addr",    fetchAddress, 1060);
    check("pt_ctrl",    controlPC, 63);
    grant = 1'b1; tick(); grant = 1'b0;
    check("pt_request_drop", request, 0);
    check("pt_count", count, 0);

    // Fill and stall
    push(32'd10, 3'd0, 1'b0);
    push(32'd20, 3'd1, 1'b0);
    push(32'd30, 3'd2, 1'b0);
    push(32'd40, 3'd3, 1'b0);
    check("full_count", count, 4);
    check("full_ready", fuReady, 0);
    check("full_head",  result, 10);
    // Deliberate protocol violation: fuValid while fuReady is low
    if (!fuReady) $display("note: pushing 50 into full queue (protocol violation, must be dropped)");
    push(32'd50, 3'd4, 1'b0);
    check("drop_count", count, 4);
    check("drop_head",  result, 10);
    check("drop_rob",   robEntry, 0);

    // Full with grant: the pop happens, but a push in the same cycle is refused
    push(32'd99, 3'd7, 1'b1);
    check("full_pop_count", count, 3);
    check("full_pop_head",  result, 20);
    pop_expect("drain_20", 32'd20);
    check("drain2_count", count, 2);
    push(32'd50, 3'd4, 1'b0);
    push(32'd60, 3'd5, 1'b0);
    check("wrap_count", count, 4);
    pop_expect("order_30", 32'd30);
    pop_expect("order_40", 32'd40);
    check("order_50_rob", robEntry, 4);
    pop_expect("order_50", 32'd50);
    check("order_60_ctrl", controlPC, 63);
    pop_expect("order_60", 32'd60);
    check("drain_count", count, 0);
    check("drain_request", request, 0);

    // Simultaneous push/pop at count=2
    push(32'd61, 3'd6, 1'b0);
    push(32'd62, 3'd7, 1'b0);
    check("sim_pre_count", count, 2);
    push(32'd70, 3'd0, 1'b1);
    check("sim_count", count, 2);
    check("sim_head",  result, 62);
    pop_expect("sim_order_62", 32'd62);
    pop_expect("sim_order_70", 32'd70);
    check("sim_empty", request, 0);

    // Flush with a concurrent push
    push(32'd81, 3'd1, 1'b0);
    push(32'd82, 3'd2, 1'b0);
    push(32'd83, 3'd3, 1'b0);
    check("fl_pre_count", count, 3);
    flush = 1'b1;
    push(32'd80, 3'd0, 1'b1);
    flush = 1'b0;
    check("fl_count",   count, 0);
    check("fl_request", request, 0);
    check("fl_ready",   fuReady, 1);
    push(32'd85, 3'd5, 1'b0);
    check("fl_refill_count", count, 1);
    check("fl_refill_head",  result, 85);
    push(32'd86, 3'd6, 1'b0);
    check("fl_refill2_count", count, 2);

    // Asynchronous clear between edges
    #2;
    clear = 1'b0;
    #1;
    check("clr_request", request, 0);
    check("clr_count",   count, 0);
    check("clr_ready",   fuReady, 1);
    check("clr_result",  result, 0);
    fuValid = 1'b1; fuResult = 32'd77;
    tick();
    fuValid = 1'b0;
    check("clr_push_ignored", count, 0);
    #2;
    clear = 1'b1;
    tick();
    push(32'd90, 3'd2, 1'b0);
    check("resume_count", count, 1);
    check("resume_head",  result, 90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_result_queue.md
# cdb_result_queue

Per-functional-unit result holding queue that sits directly upstream of the CDB arbiter. It captures completed results (value, ROB tag, redirect address, control PC) from one functional unit and presents the oldest one as a request to the arbiter. It holds that entry until the arbiter grants the bus, which decouples functional-unit completion from CDB availability. One instance per functional unit (ALU, branch), each feeding one arbiter request port.

## Interface
- WIDTH, 31, MSB index of result and address fields (32-bit data)
- ROB, 2, MSB index of ROB tag (8 entries)
- CONTROL, 6, MSB index of control PC field
- DEPTH, 4, queue entries; power of two, ≥2
- clk  input  1  clock, all state updates on rising edge
- clear  input  1  asynchronous, active-low reset; empties the queue immediately
- flush  input  1  synchronous mispredict flush; empties queue at next edge
- fuValid  input  1  functional unit presents a completed result this cycle
- fuResult  input  WIDTH+1  result value
- fuRob  input  ROB+1  destination ROB entry
- fuAddress  input  WIDTH+1  computed fetch/redirect address (branch units; don't-care for ALU)
- fuControl  input  CONTROL+1  control PC tag
- fuReady  output  1  queue can accept a push this cycle
- request  output  1  head entry valid; drives arbiter request
- grant  input  1  arbiter has selected this queue's request this cycle
- result  output  WIDTH+1  head result value
- robEntry  output  ROB+1  head ROB tag
- fetchAddress  output  WIDTH+1  head redirect address
- controlPC  output  CONTROL+1  head control PC
- count  output  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer of DEPTH entries; head pointer, tail pointer, and occupancy counter, all registered.
- Push: fuValid && fuReady at an edge writes the entry at tail, tail+1 mod DEPTH, count+1.
- Pop: request && grant at an edge frees the head entry, head+1 mod DEPTH, count−1.
- Simultaneous push and pop: both occur; count unchanged.
- fuReady = (count != DEPTH). It is registered-state only, with no combinational path from grant. When full, a pop in the same cycle does not enable a push.
- request = (count != 0). Head fields are driven from storage and hold stable while request is high and grant is low.
- grant while request is low is ignored; no state change.
- fuValid while fuReady is low: the result is dropped. This is a protocol violation, and the bench flags it.
- flush at an edge: head=tail=0, count=0. A push or pop in the same cycle is discarded, and flush wins.
- clear low, at any time: head=tail=count=0 asynchronously. The queue stays empty while clear is low, and pushes are ignored. Normal operation resumes at the first edge after clear deasserts.
- Strict FIFO order: results reach the CDB in functional-unit completion order.
- Pointers wrap modulo DEPTH with no gap; all DEPTH entries are usable.

## Timing
- Reset values: request=0, fuReady=1, count=0. result, robEntry, fetchAddress, and controlPC are all 0, because storage is cleared on reset.
- Push-to-request latency: 1 cycle. There is no bypass. A result pushed at edge N is visible on request/result after edge N.
- Grant-to-advance: the head is replaced by the next entry (or request drops) after the granting edge.
- Back-to-back grants drain one entry per cycle.
- Flush takes effect at the edge. request=0 and fuReady=1 in the following cycle.

## Test plan
- Reset: hold clear low 2 cycles, then release. Required: request=0, fuReady=1, count=0, result=0.
- Single pass-through: push result=60, rob=1, grant held high. Required: request=1, result=60, robEntry=1 one cycle after the push; request=0 the cycle after the grant edge.
- Fill and stall: push 10,20,30,40 (robs 0–3) with grant=0. Required: count=4, fuReady=0. A push of 50 with fuValid is not stored, and the head stays 10.
- Drain with wrap: from the full state, grant for 2 cycles, then push 50 and 60 with grant=0. Then grant for 4 cycles. Required: output order 30,40,50,60; count returns to 0; the tail pointer has wrapped.
- Simultaneous push/pop: count=2, push 70 with grant=1 in the same cycle. Required: count stays 2 and the head advances by one entry.
- Flush and async clear mid-operation: count=3, assert flush together with fuValid (value 80). Required: count=0 next cycle and 80 is not stored. Refill 2 entries, then drop clear between edges. Required: request=0 immediately, before the next edge.
